// File: rtl/prog_loader_if.sv
// Program-loader bus: byte stream in, instruction fetch port, status out.
// master = byte source / CPU side, slave = the loader.
interface prog_loader_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  ADDR;
  logic [20:0] INS;
  logic        CPU_HOLD;
  logic        LOADING;
  logic        DONE;
  logic        ERR;
  logic [8:0]  LEN;

  modport master (
    output RX_DATA, RX_VALID, ADDR,
    input  INS, CPU_HOLD, LOADING, DONE, ERR, LEN
  );

  modport slave (
    input  RX_DATA, RX_VALID, ADDR,
    output INS, CPU_HOLD, LOADING, DONE, ERR, LEN
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (SYNC, N, 3 bytes per word)
// into a 256x21 instruction memory and holds the CPU until a load completes.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing
// modulo-256 checksum byte over N and all payload bytes.
module prog_loader #(
  parameter logic [20:0] FILL_WORD = 21'h000000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic         CLK,
  input logic         RESET_N,
  prog_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COUNT   = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd3;
`endif
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [8:0]  len_q,   len_d;    // words visible to the CPU
  logic [8:0]  n_q,     n_d;      // frame word count, 1..256
  logic [7:0]  ptr_q,   ptr_d;    // next word to write
  logic [1:0]  phase_q, phase_d;  // byte within the current word
  logic [4:0]  b0_q,    b0_d;
  logic [7:0]  b1_q,    b1_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q,  csum_d;
`endif
  logic        we;
  logic [20:0] wdata;
  logic        last_word;

  // Memory is deliberately unreset; stale words are masked by LEN.
  logic [20:0] mem [256];

  assign wdata     = {b0_q, b1_q, bus.RX_DATA};
  assign last_word = ({1'b0, ptr_q} == (n_q - 9'd1));

  // Frame parser: next-state for every register, one byte per valid cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    n_d     = n_q;
    ptr_d   = ptr_q;
    phase_d = phase_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    we      = 1'b0;
    if (bus.RX_VALID) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.RX_DATA == SYNC_BYTE) begin
            state_d = S_COUNT;
            len_d   = 9'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
          end
        end
        S_COUNT: begin
          n_d     = (bus.RX_DATA == 8'd0) ? 9'd256 : {1'b0, bus.RX_DATA};
          ptr_d   = 8'd0;
          phase_d = 2'd0;
          state_d = S_PAYLOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q + bus.RX_DATA;
`endif
        end
        S_PAYLOAD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q + bus.RX_DATA;
`endif
          case (phase_q)
            2'd0: begin
              // Only 21 bits per word: any bit above [4:0] in b0 is malformed.
              if (bus.RX_DATA[7:5] != 3'd0) begin
                state_d = S_ERROR;
              end else begin
                b0_d    = bus.RX_DATA[4:0];
                phase_d = 2'd1;
              end
            end
            2'd1: begin
              b1_d    = bus.RX_DATA;
              phase_d = 2'd2;
            end
            default: begin
              we      = 1'b1;
              ptr_d   = ptr_q + 8'd1;
              phase_d = 2'd0;
              if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_d = S_CHECK;
`else
                state_d = S_DONE;
                len_d   = n_q;
`endif
              end
            end
          endcase
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (bus.RX_DATA == csum_q) begin
            state_d = S_DONE;
            len_d   = n_q;
          end else begin
            state_d = S_ERROR;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      len_q   <= 9'd0;
      n_q     <= 9'd0;
      ptr_q   <= 8'd0;
      phase_q <= 2'd0;
      b0_q    <= 5'd0;
      b1_q    <= 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      n_q     <= n_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Word write on the edge that accepts the third byte.
  always_ff @(posedge CLK) begin
    if (we) mem[ptr_q] <= wdata;
  end

  assign bus.INS      = ({1'b0, bus.ADDR} < len_q) ? mem[bus.ADDR] : FILL_WORD;
  assign bus.DONE     = (state_q == S_DONE);
  assign bus.ERR      = (state_q == S_ERROR);
  assign bus.CPU_HOLD = (state_q != S_DONE);
  assign bus.LOADING  = (state_q == S_COUNT) || (state_q == S_PAYLOAD)
`ifdef PROG_LOADER_CHECKSUM_EN
                        || (state_q == S_CHECK)
`endif
                        ;
  assign bus.LEN      = len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a frame-level reference model.
module tb_prog_loader;
  localparam logic [20:0] FILL = 21'h15A5A3;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  prog_loader_if bus();

  prog_loader #(.FILL_WORD(FILL), .SYNC_BYTE(SYNC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the CPU should see after each frame.
  logic [20:0] mmem [256];
  int          mlen = 0;
  logic [20:0] fw   [256];   // words of the frame being sent

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] exp_ins(input int a);
    return (a < mlen) ? mmem[a] : FILL;
  endfunction

  task automatic send(input logic [7:0] b, input int maxgap);
    repeat ($urandom_range(0, maxgap)) @(negedge CLK);
    @(negedge CLK);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    @(negedge CLK);
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'($urandom);
  endtask

  task automatic check_ins(input string tag, input int a);
    bus.ADDR = 8'(a);
    #1;
    chk(tag, 32'(bus.INS), 32'(exp_ins(a)));
  endtask

  task automatic check_status(input string tag, input bit d, input bit e);
    chk({tag, ".LEN"},      32'(bus.LEN),      32'(mlen));
    chk({tag, ".DONE"},     32'(bus.DONE),     32'(d));
    chk({tag, ".ERR"},      32'(bus.ERR),      32'(e));
    chk({tag, ".CPU_HOLD"}, 32'(bus.CPU_HOLD), 32'(!d));
    chk({tag, ".LOADING"},  32'(bus.LOADING),  32'(0));
  endtask

  // Send one frame of n words from fw[]; bad_idx >= 0 corrupts that word's
  // first byte (frame stops there), bad_cs sends a wrong checksum.
  task automatic send_frame(input string tag, input int n, input int bad_idx,
                            input bit bad_cs, input int maxgap);
    logic [7:0] sum;
    logic [7:0] b;
    bit ok;
    ok  = 1'b1;
    sum = 8'(n);
    send(SYNC, maxgap);
    send(8'(n), maxgap);
    chk({tag, ".midLOADING"}, 32'(bus.LOADING), 32'(1));
    chk({tag, ".midLEN"},     32'(bus.LEN),     32'(0));
    chk({tag, ".midHOLD"},    32'(bus.CPU_HOLD), 32'(1));
    for (int i = 0; i < n && ok; i++) begin
      b = {3'd0, fw[i][20:16]};
      if (i == bad_idx) begin
        b[7:5] = 3'($urandom_range(1, 7));
        send(b, maxgap);
        ok = 1'b0;
      end else begin
        sum += b; send(b, maxgap);
        b = fw[i][15:8]; sum += b; send(b, maxgap);
        b = fw[i][7:0];  sum += b; send(b, maxgap);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (ok) begin
      send(bad_cs ? sum + 8'd1 : sum, maxgap);
      if (bad_cs) ok = 1'b0;
    end
`endif
    if (ok) begin
      for (int i = 0; i < n; i++) mmem[i] = fw[i];
      mlen = n;
    end else begin
      mlen = 0;
    end
    check_status(tag, ok, !ok);
  endtask

  initial begin
    bus.RX_DATA  = 8'd0;
    bus.RX_VALID = 1'b0;
    bus.ADDR     = 8'd0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // After reset: nothing loaded, CPU held.
    check_status("reset", 1'b0, 1'b0);
    for (int a = 0; a < 256; a++) check_ins("reset.INS", a);

    // Two-word reference frame.
    fw[0] = 21'h0C0000;
    fw[1] = 21'h070007;
    send_frame("two", 2, -1, 1'b0, 0);
    for (int a = 0; a < 3; a++) check_ins("two.INS", a);
    chk("two.addr2fill", 32'(bus.INS), 32'(FILL));

    // Malformed b0 (0x20): error immediately, trailing bytes ignored.
    fw[0] = 21'h000000;
    send(SYNC, 0);
    send(8'h01, 0);
    send(8'h20, 0);
    mlen = 0;
    check_status("badb0", 1'b0, 1'b1);
    send(8'h00, 0);
    send(8'h00, 0);
    check_status("badb0.tail", 1'b0, 1'b1);
    check_ins("badb0.INS", 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    fw[0] = 21'h000005;
    send_frame("csbad", 1, -1, 1'b1, 0);
    check_ins("csbad.INS", 0);
    send_frame("csgood", 1, -1, 1'b0, 0);
    check_ins("csgood.INS", 0);
`endif

    // Reset in the middle of a frame abandons the load.
    send(SYNC, 0);
    send(8'h03, 0);
    send(8'h01, 0);
    chk("rstmid.LOADING", 32'(bus.LOADING), 32'(1));
    RESET_N = 1'b0;
    #1;
    mlen = 0;
    chk("rstmid.HOLD", 32'(bus.CPU_HOLD), 32'(1));
    chk("rstmid.LEN",  32'(bus.LEN),      32'(0));
    chk("rstmid.DONE", 32'(bus.DONE),     32'(0));
    @(negedge CLK);
    RESET_N = 1'b1;
    check_status("rstmid.after", 1'b0, 1'b0);
    fw[0] = 21'h1F00A5;
    send_frame("rstmid.reload", 1, -1, 1'b0, 0);
    check_ins("rstmid.reload.INS0", 0);
    check_ins("rstmid.reload.INS1", 1);

    // Full 256-word frame (count byte 0) with gaps in RX_VALID.
    for (int i = 0; i < 256; i++) fw[i] = 21'($urandom);
    fw[7][15:0] = 16'hA5A5;
    send_frame("full", 256, -1, 1'b0, 2);
    check_ins("full.INS255", 255);
    check_ins("full.INS0", 0);
    check_ins("full.INS7", 7);
    for (int k = 0; k < 8; k++) check_ins("full.INSr", $urandom_range(0, 255));

    // Random frames, some corrupted, with junk bytes between them.
    for (int it = 0; it < 30; it++) begin
      int n, bad;
      bit bcs;
      logic [7:0] j;
      n   = $urandom_range(1, 12);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      bcs = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < n; i++) fw[i] = 21'($urandom);
      if (it % 3 == 0) fw[0][15:0] = 16'hA5A5;
      repeat ($urandom_range(0, 3)) begin
        j = 8'($urandom);
        if (j == SYNC) j = 8'h00;
        send(j, 1);
      end
      send_frame("rnd", n, bad, bcs, 2);
      for (int a = 0; a < 14; a++) check_ins("rnd.INS", a);
      check_ins("rnd.INShi", $urandom_range(14, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the bench itself stalls.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
